// File: rtl/mo_matmul_pkg.sv
// Shared constants, request opcodes and FSM states for the mo_matmul engine.
package mo_matmul_pkg;

  localparam int DW    = 10;
  localparam int OW    = 20;
  localparam int MAX_R = 32;

  localparam logic [2:0] GET_N   = 3'b000;
  localparam logic [2:0] GET_R   = 3'b001;
  localparam logic [2:0] READ_A  = 3'b010;
  localparam logic [2:0] READ_X  = 3'b011;
  localparam logic [2:0] READ_B  = 3'b100;
  localparam logic [2:0] WRITE_Y = 3'b101;
  localparam logic [2:0] IDLE    = 3'b111;

  typedef enum logic [2:0] {
    S_N,
    S_R,
    S_A,
    S_B,
    S_X,
    S_W,
    S_DONE
  } state_t;

endpackage

// File: rtl/mo_row_cache.sv
// Register file holding one row of A: one write port, one indexed read port.
module mo_row_cache #(
  parameter int DW    = 10,
  parameter int MAX_R = 32,
  parameter int AW    = $clog2(MAX_R)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [MAX_R];

  // Clear the whole row on reset, otherwise store the incoming A element.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < MAX_R; e++) begin
        mem[e] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mo_matmul.sv
// Y = A*X + B engine: fetches operands over the request bus, streams Y row-major.
module mo_matmul #(
  parameter int DW    = mo_matmul_pkg::DW,
  parameter int OW    = mo_matmul_pkg::OW,
  parameter int MAX_R = mo_matmul_pkg::MAX_R
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  output logic [9:0]    i,
  output logic [9:0]    j,
  output logic [2:0]    opcode,
  output logic [OW-1:0] out_data,
  output logic          fin
);

  import mo_matmul_pkg::*;

  localparam int AW = $clog2(MAX_R);

  state_t          state;
  logic [DW-1:0]   n;
  logic [DW-1:0]   r;
  logic [DW-1:0]   p;
  logic [DW-1:0]   q;
  logic [DW-1:0]   k;
  logic [OW-1:0]   acc;
  logic [DW-1:0]   cache_rd;
  logic            cache_we;
  logic [2*DW-1:0] prod;
  logic [OW-1:0]   acc_next;
  logic            k_last;
  logic            q_last;
  logic            p_last;

  // The A row is captured while READ_A requests are in flight and read back during READ_X.
  assign cache_we = (state == S_A);

  mo_row_cache #(
    .DW    (DW),
    .MAX_R (MAX_R),
    .AW    (AW)
  ) u_row_cache (
    .clk   (clk),
    .reset (reset),
    .we    (cache_we),
    .waddr (k[AW-1:0]),
    .wdata (in_data),
    .raddr (k[AW-1:0]),
    .rdata (cache_rd)
  );

  assign prod     = (2*DW)'(cache_rd) * (2*DW)'(in_data);
  assign acc_next = acc + OW'(prod);
  assign k_last   = (k == r - DW'(1));
  assign q_last   = (q == n - DW'(1));
  assign p_last   = (p == n - DW'(1));

  // Request sequencer and MAC: every output is registered and is the request for the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_N;
      opcode   <= GET_N;
      i        <= '0;
      j        <= '0;
      out_data <= '0;
      fin      <= 1'b0;
      n        <= '0;
      r        <= '0;
      p        <= '0;
      q        <= '0;
      k        <= '0;
      acc      <= '0;
    end else begin
      case (state)
        S_N: begin
          n      <= in_data;
          state  <= S_R;
          opcode <= GET_R;
        end
        S_R: begin
          r <= in_data;
          p <= '0;
          q <= '0;
          k <= '0;
          i <= '0;
          j <= '0;
          if (n == '0) begin
            state  <= S_DONE;
            opcode <= IDLE;
          end else if (in_data == '0) begin
            state  <= S_B;
            opcode <= READ_B;
          end else begin
            state  <= S_A;
            opcode <= READ_A;
          end
        end
        S_A: begin
          i <= 10'(p);
          if (k_last) begin
            k      <= '0;
            q      <= '0;
            state  <= S_B;
            opcode <= READ_B;
            j      <= '0;
          end else begin
            k      <= k + DW'(1);
            opcode <= READ_A;
            j      <= 10'(k + DW'(1));
          end
        end
        S_B: begin
          acc <= OW'(in_data);
          k   <= '0;
          j   <= 10'(q);
          if (r == '0) begin
            state    <= S_W;
            opcode   <= WRITE_Y;
            out_data <= OW'(in_data);
            i        <= 10'(p);
          end else begin
            state  <= S_X;
            opcode <= READ_X;
            i      <= '0;
          end
        end
        S_X: begin
          acc <= acc_next;
          j   <= 10'(q);
          if (k_last) begin
            state    <= S_W;
            opcode   <= WRITE_Y;
            out_data <= acc_next;
            i        <= 10'(p);
          end else begin
            k      <= k + DW'(1);
            opcode <= READ_X;
            i      <= 10'(k + DW'(1));
          end
        end
        S_W: begin
          if (q_last) begin
            if (p_last) begin
              state  <= S_DONE;
              opcode <= IDLE;
              i      <= '0;
              j      <= '0;
            end else begin
              p <= p + DW'(1);
              q <= '0;
              k <= '0;
              i <= 10'(p + DW'(1));
              j <= '0;
              if (r == '0) begin
                state  <= S_B;
                opcode <= READ_B;
              end else begin
                state  <= S_A;
                opcode <= READ_A;
              end
            end
          end else begin
            q      <= q + DW'(1);
            state  <= S_B;
            opcode <= READ_B;
            i      <= 10'(p);
            j      <= 10'(q + DW'(1));
          end
        end
        S_DONE: begin
          fin    <= 1'b1;
          opcode <= IDLE;
          i      <= '0;
          j      <= '0;
        end
        default: begin
          state  <= S_N;
          opcode <= GET_N;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mo_matmul.sv
// Self-checking bench for mo_matmul: memory agent, request/result scoreboard, vector table.
module tb_mo_matmul;

  localparam logic [2:0] OP_GET_N   = 3'b000;
  localparam logic [2:0] OP_GET_R   = 3'b001;
  localparam logic [2:0] OP_READ_A  = 3'b010;
  localparam logic [2:0] OP_READ_X  = 3'b011;
  localparam logic [2:0] OP_READ_B  = 3'b100;
  localparam logic [2:0] OP_WRITE_Y = 3'b101;
  localparam logic [2:0] OP_IDLE    = 3'b111;

  typedef struct packed {
    int               n;
    int               r;
    int               cycles;
    logic [15:0][9:0] a;
    logic [15:0][9:0] x;
    logic [15:0][9:0] b;
  } test_vec_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [9:0]  i;
    logic [9:0]  j;
    logic [19:0] y;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [9:0]  in_data;
  logic [9:0]  i;
  logic [9:0]  j;
  logic [2:0]  opcode;
  logic [19:0] out_data;
  logic        fin;

  int checks;
  int errors;
  int cnt_a;
  int cnt_x;
  int cnt_b;
  int cnt_w;
  int edge_cnt;
  int fin_edge;
  bit ab;

  test_vec_t vecs[6];
  test_vec_t cur;
  exp_t      exp_q[$];

  mo_matmul dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .i        (i),
    .j        (j),
    .opcode   (opcode),
    .out_data (out_data),
    .fin      (fin)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic test_vec_t blank(input int n, input int r, input int cycles);
    test_vec_t v;
    v = '0;
    v.n = n;
    v.r = r;
    v.cycles = cycles;
    return v;
  endfunction

  function automatic exp_t mkExp(input logic [2:0] op, input int ii, input int jj, input longint y);
    exp_t e;
    e.op = op;
    e.i  = 10'(ii);
    e.j  = 10'(jj);
    e.y  = 20'(y);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Load a vector and build the expected request stream, with Y = A*X + B mod 2^20.
  task automatic applyStimulus(input int idx);
    longint acc;
    cur = vecs[idx];
    exp_q.delete();
    cnt_a = 0;
    cnt_x = 0;
    cnt_b = 0;
    cnt_w = 0;
    exp_q.push_back(mkExp(OP_GET_N, 0, 0, 0));
    exp_q.push_back(mkExp(OP_GET_R, 0, 0, 0));
    for (int p = 0; p < cur.n; p++) begin
      for (int k = 0; k < cur.r; k++) exp_q.push_back(mkExp(OP_READ_A, p, k, 0));
      for (int q = 0; q < cur.n; q++) begin
        exp_q.push_back(mkExp(OP_READ_B, p, q, 0));
        acc = longint'(cur.b[p*4+q]);
        for (int k = 0; k < cur.r; k++) begin
          exp_q.push_back(mkExp(OP_READ_X, k, q, 0));
          acc = (acc + longint'(cur.a[p*4+k]) * longint'(cur.x[k*4+q])) % 1048576;
        end
        exp_q.push_back(mkExp(OP_WRITE_Y, p, q, acc));
      end
    end
  endtask

  // Act as the memory agent for the current request and score it against the expected stream.
  task automatic serve();
    exp_t e;
    int   idx;
    idx = (int'(i) < 4 && int'(j) < 4) ? int'(i) * 4 + int'(j) : 0;
    case (opcode)
      OP_READ_A:  cnt_a++;
      OP_READ_X:  cnt_x++;
      OP_READ_B:  cnt_b++;
      OP_WRITE_Y: cnt_w++;
      default: ;
    endcase
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("request", 64'({opcode, i, j}), 64'({e.op, e.i, e.j}));
      checkOutput("fin_early", 64'(fin), 64'(0));
      if (e.op == OP_WRITE_Y) checkOutput("y_value", 64'(out_data), 64'(e.y));
    end else begin
      checkOutput("idle_request", 64'({opcode, i, j}), 64'({OP_IDLE, 10'd0, 10'd0}));
    end
    case (opcode)
      OP_GET_N:  in_data = 10'(cur.n);
      OP_GET_R:  in_data = 10'(cur.r);
      OP_READ_A: in_data = cur.a[idx];
      OP_READ_X: in_data = cur.x[idx];
      OP_READ_B: in_data = cur.b[idx];
      default:   in_data = 10'($urandom_range(0, 1023));
    endcase
  endtask

  // Reset, release, and run one vector; optionally re-assert reset on reaching a given A row.
  task automatic runVector(input int idx, input int abort_row, output bit aborted);
    aborted = 1'b0;
    applyStimulus(idx);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_values", 64'({opcode, i, j, out_data, fin}),
                64'({OP_GET_N, 10'd0, 10'd0, 20'd0, 1'b0}));
    reset    = 1'b1;
    edge_cnt = 0;
    fin_edge = -1;
    serve();
    while (edge_cnt < cur.cycles + 8) begin
      @(posedge clk);
      edge_cnt++;
      @(negedge clk);
      if (fin && fin_edge < 0) fin_edge = edge_cnt;
      if (abort_row >= 0 && opcode == OP_READ_A && int'(i) == abort_row) begin
        reset = 1'b0;
        #1;
        checkOutput("reset_midrun", 64'({opcode, i, j, out_data, fin}),
                    64'({OP_GET_N, 10'd0, 10'd0, 20'd0, 1'b0}));
        aborted = 1'b1;
        return;
      end
      serve();
    end
    checkOutput("fin_edge", 64'(fin_edge), 64'(cur.cycles));
    checkOutput("fin_sticky", 64'(fin), 64'(1));
    checkOutput("pending_requests", 64'(exp_q.size()), 64'(0));
    checkOutput("count_read_a", 64'(cnt_a), 64'(cur.n * cur.r));
    checkOutput("count_read_x", 64'(cnt_x), 64'(cur.n * cur.n * cur.r));
    checkOutput("count_read_b", 64'(cnt_b), 64'(cur.n * cur.n));
    checkOutput("count_write_y", 64'(cnt_w), 64'(cur.n * cur.n));
  endtask

  // Vector table, then the mid-run reset sequence, then the summary.
  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    in_data = '0;

    vecs[0] = blank(2, 2, 23);
    vecs[0].a[0] = 10'd1; vecs[0].a[1] = 10'd2; vecs[0].a[4] = 10'd3; vecs[0].a[5] = 10'd4;
    vecs[0].x[0] = 10'd5; vecs[0].x[1] = 10'd6; vecs[0].x[4] = 10'd7; vecs[0].x[5] = 10'd8;
    for (int p = 0; p < 2; p++)
      for (int q = 0; q < 2; q++) vecs[0].b[p*4+q] = 10'd1;

    vecs[1] = blank(2, 0, 11);
    vecs[1].b[0] = 10'd9; vecs[1].b[1] = 10'd8; vecs[1].b[4] = 10'd7; vecs[1].b[5] = 10'd6;

    vecs[2] = blank(1, 2, 9);
    vecs[2].a[0] = 10'd1023; vecs[2].a[1] = 10'd1023;
    vecs[2].x[0] = 10'd1023; vecs[2].x[4] = 10'd1023;
    vecs[2].b[0] = 10'd1023;

    vecs[3] = blank(3, 1, 33);
    for (int p = 0; p < 3; p++) begin
      vecs[3].a[p*4] = 10'(p + 2);
      vecs[3].x[p]   = 10'(p * 100 + 7);
      for (int q = 0; q < 3; q++) vecs[3].b[p*4+q] = 10'(p * 3 + q);
    end

    vecs[4] = blank(0, 2, 3);

    vecs[5] = blank(3, 3, 57);
    for (int e = 0; e < 16; e++) begin
      vecs[5].a[e] = 10'($urandom_range(0, 1023));
      vecs[5].x[e] = 10'($urandom_range(0, 1023));
      vecs[5].b[e] = 10'($urandom_range(0, 1023));
    end

    for (int t = 0; t < 6; t++) runVector(t, -1, ab);

    runVector(3, 1, ab);
    checkOutput("midrun_abort_reached", 64'(ab), 64'(1));
    runVector(3, -1, ab);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
